rv32_core: RTL and testbench

Single-cycle RV32I integer core with machine-mode external-interrupt support and a debug inspection/stepping port. It contains the PC, a 32×32 register file, a minimal CSR set, and word-addressed instruction ROM and data RAM. It is the top of the CPU and is driven directly by the board or bench clock, reset, interrupt line and debug controls.

---
 rtl/rv32_core.sv | 232 +++++++++++++++++++++++
 tb/tb_rv32_core.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_core.sv
// rtl/rv32_core.sv - single-cycle RV32I core with M-mode external interrupt and debug port
module rv32_core #(
   parameter int    IMEM_WORDS = 256,
   parameter int    DMEM_WORDS = 256,
   parameter string IMEM_INIT  = "rom.hex"
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        interrupter,
   input  logic        debug_en,
   input  logic        debug_step,
   input  logic [6:0]  debug_addr,
   output logic [31:0] debug_data
);
   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_WORDS);

   logic [31:0] imem [IMEM_WORDS];
   logic [31:0] dmem [DMEM_WORDS];

   logic [31:0] regs_q [32];
   logic [31:0] pc_q, pc_d, mtvec_q, mepc_q, mcause_q;
   logic        mie_q, mpie_q, step_q;

   logic [31:0] instr, rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [11:0] csr_addr;

   assign instr    = imem[pc_q[IAW+1:2]];
   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign rd       = instr[11:7];
   assign csr_addr = instr[31:20];
   assign rs1_v    = regs_q[instr[19:15]];
   assign rs2_v    = regs_q[instr[24:20]];
   assign imm_i    = {{20{instr[31]}}, instr[31:20]};
   assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u    = {instr[31:12], 12'b0};
   assign imm_j    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

   logic        is_op, op_ok, br_taken, ld_ok, st_ok;
   logic [31:0] alu_b, alu_y, mem_addr, ld_word, ld_val, st_word, csr_old, csr_new;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign is_op    = (opcode == 7'b0110011);
   assign alu_b    = is_op ? rs2_v : imm_i;
   assign op_ok    = (instr[31:25] == 7'h00) ||
                     (instr[31:25] == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
   assign mem_addr = rs1_v + ((opcode == 7'b0100011) ? imm_s : imm_i);
   assign ld_word  = dmem[mem_addr[DAW+1:2]];
   assign ld_byte  = ld_word[{mem_addr[1:0], 3'b000} +: 8];
   assign ld_half  = mem_addr[1] ? ld_word[31:16] : ld_word[15:0];

   // integer ALU shared by OP and OP-IMM; SUB only exists in the register form
   always_comb begin
      alu_y = '0;
      case (funct3)
         3'b000: alu_y = (is_op && instr[30]) ? rs1_v - alu_b : rs1_v + alu_b;
         3'b001: alu_y = rs1_v << alu_b[4:0];
         3'b010: alu_y = {31'b0, $signed(rs1_v) < $signed(alu_b)};
         3'b011: alu_y = {31'b0, rs1_v < alu_b};
         3'b100: alu_y = rs1_v ^ alu_b;
         3'b101: alu_y = instr[30] ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
         3'b110: alu_y = rs1_v | alu_b;
         default: alu_y = rs1_v & alu_b;
      endcase
   end

   // branch condition, undefined funct3 values never branch
   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000: br_taken = (rs1_v == rs2_v);
         3'b001: br_taken = (rs1_v != rs2_v);
         3'b100: br_taken = ($signed(rs1_v) < $signed(rs2_v));
         3'b101: br_taken = ($signed(rs1_v) >= $signed(rs2_v));
         3'b110: br_taken = (rs1_v < rs2_v);
         3'b111: br_taken = (rs1_v >= rs2_v);
         default: br_taken = 1'b0;
      endcase
   end

   // load lane extraction and store lane merge into the addressed word
   always_comb begin
      ld_ok   = 1'b1;
      st_ok   = 1'b1;
      ld_val  = ld_word;
      st_word = ld_word;
      case (funct3)
         3'b000: ld_val = {{24{ld_byte[7]}}, ld_byte};
         3'b001: ld_val = {{16{ld_half[15]}}, ld_half};
         3'b010: ld_val = ld_word;
         3'b100: ld_val = {24'b0, ld_byte};
         3'b101: ld_val = {16'b0, ld_half};
         default: ld_ok = 1'b0;
      endcase
      case (funct3)
         3'b000: st_word[{mem_addr[1:0], 3'b000} +: 8] = rs2_v[7:0];
         3'b001: st_word[{mem_addr[1], 4'b0000} +: 16] = rs2_v[15:0];
         3'b010: st_word = rs2_v;
         default: st_ok = 1'b0;
      endcase
   end

   // CSR read mux and read-modify-write value
   always_comb begin
      case (csr_addr)
         12'h300: csr_old = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
         12'h305: csr_old = mtvec_q;
         12'h341: csr_old = mepc_q;
         12'h342: csr_old = mcause_q;
         default: csr_old = '0;
      endcase
      case (funct3)
         3'b001:  csr_new = rs1_v;
         3'b010:  csr_new = csr_old | rs1_v;
         default: csr_new = csr_old & ~rs1_v;
      endcase
   end

   logic        rd_we, csr_we, dmem_we, is_mret, adv, take_irq;
   logic [31:0] rd_wd;

   assign adv      = !debug_en || (debug_step && !step_q);
   assign take_irq = interrupter && mie_q;

   // main decode: next PC and write enables for the current instruction
   always_comb begin
      pc_d    = pc_q + 32'd4;
      rd_we   = 1'b0;
      rd_wd   = '0;
      csr_we  = 1'b0;
      dmem_we = 1'b0;
      is_mret = 1'b0;
      case (opcode)
         7'b0110111: begin rd_we = 1'b1; rd_wd = imm_u; end
         7'b0010111: begin rd_we = 1'b1; rd_wd = pc_q + imm_u; end
         7'b1101111: begin rd_we = 1'b1; rd_wd = pc_q + 32'd4; pc_d = pc_q + imm_j; end
         7'b1100111: if (funct3 == 3'b000) begin
            rd_we = 1'b1;
            rd_wd = pc_q + 32'd4;
            pc_d  = (rs1_v + imm_i) & ~32'd1;
         end
         7'b1100011: if (br_taken) pc_d = pc_q + imm_b;
         7'b0000011: begin rd_we = ld_ok; rd_wd = ld_val; end
         7'b0100011: dmem_we = st_ok;
         7'b0010011: begin rd_we = 1'b1; rd_wd = alu_y; end
         7'b0110011: begin rd_we = op_ok; rd_wd = alu_y; end
         7'b1110011: begin
            if (instr == 32'h30200073) begin
               is_mret = 1'b1;
               pc_d    = mepc_q;
            end else if (funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b011) begin
               rd_we  = 1'b1;
               rd_wd  = csr_old;
               csr_we = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // architectural state: PC, register file, CSRs and step edge detector
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q     <= '0;
         mtvec_q  <= '0;
         mepc_q   <= '0;
         mcause_q <= '0;
         mie_q    <= 1'b0;
         mpie_q   <= 1'b0;
         step_q   <= 1'b0;
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else begin
         step_q <= debug_step;
         if (adv) begin
            if (take_irq) begin
               mepc_q   <= pc_q;
               mcause_q <= 32'h8000000B;
               mpie_q   <= mie_q;
               mie_q    <= 1'b0;
               pc_q     <= mtvec_q;
            end else begin
               pc_q <= pc_d;
               if (rd_we && rd != 5'd0) regs_q[rd] <= rd_wd;
               if (is_mret) begin
                  mie_q  <= mpie_q;
                  mpie_q <= 1'b1;
               end
               if (csr_we) begin
                  case (csr_addr)
                     12'h300: begin mie_q <= csr_new[3]; mpie_q <= csr_new[7]; end
                     12'h305: mtvec_q  <= {csr_new[31:2], 2'b00};
                     12'h341: mepc_q   <= {csr_new[31:2], 2'b00};
                     12'h342: mcause_q <= csr_new;
                     default: ;
                  endcase
               end
            end
         end
      end
   end

   // data RAM write port, contents survive reset
   always_ff @(posedge clk) begin
      if (rst && adv && !take_irq && dmem_we) dmem[mem_addr[DAW+1:2]] <= st_word;
   end

   // combinational debug read
   always_comb begin
      debug_data = '0;
      if (debug_addr[6:5] == 2'b00) debug_data = regs_q[debug_addr[4:0]];
      else begin
         case (debug_addr)
            7'h20: debug_data = pc_q;
            7'h21: debug_data = instr;
            7'h22: debug_data = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
            7'h23: debug_data = mtvec_q;
            7'h24: debug_data = mepc_q;
            7'h25: debug_data = mcause_q;
            default: debug_data = '0;
         endcase
      end
   end

   logic unused_bits;
   assign unused_bits = ^{pc_q[1:0], pc_q[31:IAW+2], mem_addr[31:DAW+2]};
endmodule

// File: tb/tb_rv32_core.sv
// tb/tb_rv32_core.sv - directed self-checking bench for rv32_core
module tb_rv32_core;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        interrupter = 1'b0;
   logic        debug_en = 1'b0;
   logic        debug_step = 1'b0;
   logic [6:0]  debug_addr = '0;
   logic [31:0] debug_data;

   int total = 0;
   int bad = 0;

   rv32_core #(.IMEM_INIT("")) dut (
      .clk(clk), .rst(rst), .interrupter(interrupter), .debug_en(debug_en),
      .debug_step(debug_step), .debug_addr(debug_addr), .debug_data(debug_data)
   );

   always #50 clk = ~clk;

   function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
   endfunction
   function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   task automatic wr(input int byte_addr, input logic [31:0] w);
      dut.imem[byte_addr >> 2] = w;
   endtask

   task automatic hold_reset();
      rst = 1'b0;
      interrupter = 1'b0;
      debug_en = 1'b0;
      debug_step = 1'b0;
      for (int i = 0; i < 256; i++) dut.imem[i] = 32'h00000013;
      @(negedge clk);
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic step_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rd_dbg(input logic [6:0] a, output logic [31:0] v);
      debug_addr = a;
      #1;
      v = debug_data;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      hold_reset();
      wr(0, i_t(12'd5, 5'd0, 3'b000, 5'd1, 7'h13));
      wr(4, i_t(12'hFF9, 5'd1, 3'b000, 5'd2, 7'h13));
      step_n(3);
      rd_dbg(7'h20, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", v, 32'h0); end
      rd_dbg(7'h01, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_x1 got=%h exp=%h", v, 32'h0); end
      release_rst();
      step_n(2);
      rd_dbg(7'h01, v); total++; if (v !== 32'h5) begin bad++; $display("FAIL addi_x1 got=%h exp=%h", v, 32'h5); end
      rd_dbg(7'h02, v); total++; if (v !== 32'hFFFFFFFE) begin bad++; $display("FAIL addi_x2 got=%h exp=%h", v, 32'hFFFFFFFE); end
      rd_dbg(7'h20, v); total++; if (v !== 32'h8) begin bad++; $display("FAIL pc_after2 got=%h exp=%h", v, 32'h8); end
      rst = 1'b0;
      rd_dbg(7'h20, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL async_reset_pc got=%h exp=%h", v, 32'h0); end
      rd_dbg(7'h02, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL async_reset_x2 got=%h exp=%h", v, 32'h0); end
   endtask

   task automatic test_memory();
      logic [31:0] v;
      hold_reset();
      wr(8'h00, {20'h12345, 5'd3, 7'h37});
      wr(8'h04, i_t(12'h678, 5'd3, 3'b000, 5'd3, 7'h13));
      wr(8'h08, s_t(12'd0, 5'd3, 5'd0, 3'b010));
      wr(8'h0C, i_t(12'd1, 5'd0, 3'b000, 5'd4, 7'h03));
      wr(8'h10, i_t(12'd2, 5'd0, 3'b101, 5'd5, 7'h03));
      wr(8'h14, i_t(12'hF80, 5'd0, 3'b000, 5'd7, 7'h13));
      wr(8'h18, s_t(12'd0, 5'd7, 5'd0, 3'b000));
      wr(8'h1C, i_t(12'd0, 5'd0, 3'b000, 5'd8, 7'h03));
      wr(8'h20, i_t(12'd0, 5'd0, 3'b010, 5'd9, 7'h03));
      release_rst();
      step_n(12);
      rd_dbg(7'h03, v); total++; if (v !== 32'h12345678) begin bad++; $display("FAIL lui_addi got=%h exp=%h", v, 32'h12345678); end
      rd_dbg(7'h04, v); total++; if (v !== 32'h00000056) begin bad++; $display("FAIL lb_byte1 got=%h exp=%h", v, 32'h56); end
      rd_dbg(7'h05, v); total++; if (v !== 32'h00001234) begin bad++; $display("FAIL lhu_upper got=%h exp=%h", v, 32'h1234); end
      rd_dbg(7'h08, v); total++; if (v !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_sext got=%h exp=%h", v, 32'hFFFFFF80); end
      rd_dbg(7'h09, v); total++; if (v !== 32'h12345680) begin bad++; $display("FAIL sb_merge got=%h exp=%h", v, 32'h12345680); end
   endtask

   task automatic test_alu_jump();
      logic [31:0] v;
      hold_reset();
      wr(8'h00, i_t(12'hFF0, 5'd0, 3'b000, 5'd1, 7'h13));
      wr(8'h04, i_t(12'h402, 5'd1, 3'b101, 5'd2, 7'h13));
      wr(8'h08, i_t(12'h002, 5'd1, 3'b101, 5'd3, 7'h13));
      wr(8'h0C, r_t(7'h20, 5'd1, 5'd0, 3'b000, 5'd4));
      wr(8'h10, r_t(7'h00, 5'd0, 5'd1, 3'b010, 5'd5));
      wr(8'h14, j_t(21'h8, 5'd6));
      wr(8'h18, i_t(12'd1, 5'd0, 3'b000, 5'd7, 7'h13));
      wr(8'h1C, i_t(12'h029, 5'd0, 3'b000, 5'd8, 7'h67));
      wr(8'h28, j_t(21'h0, 5'd0));
      release_rst();
      step_n(10);
      rd_dbg(7'h02, v); total++; if (v !== 32'hFFFFFFFC) begin bad++; $display("FAIL srai got=%h exp=%h", v, 32'hFFFFFFFC); end
      rd_dbg(7'h03, v); total++; if (v !== 32'h3FFFFFFC) begin bad++; $display("FAIL srli got=%h exp=%h", v, 32'h3FFFFFFC); end
      rd_dbg(7'h04, v); total++; if (v !== 32'h10) begin bad++; $display("FAIL sub got=%h exp=%h", v, 32'h10); end
      rd_dbg(7'h05, v); total++; if (v !== 32'h1) begin bad++; $display("FAIL slt got=%h exp=%h", v, 32'h1); end
      rd_dbg(7'h06, v); total++; if (v !== 32'h18) begin bad++; $display("FAIL jal_link got=%h exp=%h", v, 32'h18); end
      rd_dbg(7'h07, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL jal_skip got=%h exp=%h", v, 32'h0); end
      rd_dbg(7'h08, v); total++; if (v !== 32'h20) begin bad++; $display("FAIL jalr_link got=%h exp=%h", v, 32'h20); end
      rd_dbg(7'h20, v); total++; if (v !== 32'h28) begin bad++; $display("FAIL jalr_target got=%h exp=%h", v, 32'h28); end
   endtask

   task automatic test_branch();
      logic [31:0] v;
      hold_reset();
      wr(8'h00, i_t(12'd0, 5'd0, 3'b000, 5'd1, 7'h13));
      wr(8'h04, i_t(12'd3, 5'd0, 3'b000, 5'd2, 7'h13));
      wr(8'h08, i_t(12'd1, 5'd1, 3'b000, 5'd1, 7'h13));
      wr(8'h0C, b_t(13'h1FFC, 5'd2, 5'd1, 3'b001));
      wr(8'h10, j_t(21'h0, 5'd0));
      release_rst();
      step_n(12);
      rd_dbg(7'h01, v); total++; if (v !== 32'h3) begin bad++; $display("FAIL loop_count got=%h exp=%h", v, 32'h3); end
      rd_dbg(7'h20, v); total++; if (v !== 32'h10) begin bad++; $display("FAIL loop_exit_pc got=%h exp=%h", v, 32'h10); end
   endtask

   task automatic test_csr();
      logic [31:0] v;
      hold_reset();
      wr(8'h00, i_t(12'h040, 5'd0, 3'b000, 5'd6, 7'h13));
      wr(8'h04, i_t(12'h305, 5'd6, 3'b001, 5'd0, 7'h73));
      wr(8'h08, i_t(12'h305, 5'd0, 3'b010, 5'd7, 7'h73));
      wr(8'h0C, 32'h00000073);
      wr(8'h10, i_t(12'h007, 5'd0, 3'b000, 5'd9, 7'h13));
      wr(8'h14, i_t(12'h341, 5'd9, 3'b001, 5'd10, 7'h73));
      release_rst();
      step_n(6);
      rd_dbg(7'h07, v); total++; if (v !== 32'h40) begin bad++; $display("FAIL csrrs_old got=%h exp=%h", v, 32'h40); end
      rd_dbg(7'h23, v); total++; if (v !== 32'h40) begin bad++; $display("FAIL dbg_mtvec got=%h exp=%h", v, 32'h40); end
      rd_dbg(7'h24, v); total++; if (v !== 32'h4) begin bad++; $display("FAIL mepc_align got=%h exp=%h", v, 32'h4); end
      rd_dbg(7'h20, v); total++; if (v !== 32'h18) begin bad++; $display("FAIL ecall_nop_pc got=%h exp=%h", v, 32'h18); end
   endtask

   task automatic test_interrupt();
      logic [31:0] v;
      hold_reset();
      wr(8'h00, i_t(12'h040, 5'd0, 3'b000, 5'd6, 7'h13));
      wr(8'h04, i_t(12'h305, 5'd6, 3'b001, 5'd0, 7'h73));
      wr(8'h08, i_t(12'h008, 5'd0, 3'b000, 5'd8, 7'h13));
      wr(8'h0C, i_t(12'h300, 5'd8, 3'b010, 5'd0, 7'h73));
      wr(8'h10, i_t(12'd1, 5'd1, 3'b000, 5'd1, 7'h13));
      wr(8'h14, j_t(21'h1FFFFC, 5'd0));
      wr(8'h40, 32'h30200073);
      interrupter = 1'b1;
      release_rst();
      step_n(3);
      rd_dbg(7'h20, v); total++; if (v !== 32'h0C) begin bad++; $display("FAIL irq_masked_pc got=%h exp=%h", v, 32'h0C); end
      interrupter = 1'b0;
      step_n(1);
      rd_dbg(7'h22, v); total++; if (v !== 32'h08) begin bad++; $display("FAIL mie_set got=%h exp=%h", v, 32'h08); end
      step_n(4);
      rd_dbg(7'h01, v); total++; if (v !== 32'h2) begin bad++; $display("FAIL loop_x1 got=%h exp=%h", v, 32'h2); end
      interrupter = 1'b1;
      step_n(1);
      rd_dbg(7'h20, v); total++; if (v !== 32'h40) begin bad++; $display("FAIL irq_pc got=%h exp=%h", v, 32'h40); end
      rd_dbg(7'h25, v); total++; if (v !== 32'h8000000B) begin bad++; $display("FAIL irq_mcause got=%h exp=%h", v, 32'h8000000B); end
      rd_dbg(7'h24, v); total++; if (v !== 32'h10) begin bad++; $display("FAIL irq_mepc got=%h exp=%h", v, 32'h10); end
      rd_dbg(7'h22, v); total++; if (v !== 32'h80) begin bad++; $display("FAIL irq_mstatus got=%h exp=%h", v, 32'h80); end
      rd_dbg(7'h01, v); total++; if (v !== 32'h2) begin bad++; $display("FAIL irq_skip_x1 got=%h exp=%h", v, 32'h2); end
      step_n(1);
      rd_dbg(7'h20, v); total++; if (v !== 32'h10) begin bad++; $display("FAIL mret_pc got=%h exp=%h", v, 32'h10); end
      rd_dbg(7'h22, v); total++; if ((v & 32'h8) !== 32'h8) begin bad++; $display("FAIL mret_mie got=%h exp=%h", v & 32'h8, 32'h8); end
      step_n(1);
      rd_dbg(7'h20, v); total++; if (v !== 32'h40) begin bad++; $display("FAIL reentry_pc got=%h exp=%h", v, 32'h40); end
      rd_dbg(7'h01, v); total++; if (v !== 32'h2) begin bad++; $display("FAIL reentry_x1 got=%h exp=%h", v, 32'h2); end
      interrupter = 1'b0;
      step_n(1);
      rd_dbg(7'h20, v); total++; if (v !== 32'h10) begin bad++; $display("FAIL mret_low_pc got=%h exp=%h", v, 32'h10); end
      step_n(2);
      rd_dbg(7'h01, v); total++; if (v !== 32'h3) begin bad++; $display("FAIL resume_x1 got=%h exp=%h", v, 32'h3); end
   endtask

   task automatic test_step();
      logic [31:0] v;
      hold_reset();
      for (int a = 0; a < 64; a += 4) wr(a, i_t(12'd1, 5'd1, 3'b000, 5'd1, 7'h13));
      debug_en = 1'b1;
      release_rst();
      step_n(10);
      rd_dbg(7'h20, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL step_idle_pc got=%h exp=%h", v, 32'h0); end
      rd_dbg(7'h01, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL step_idle_x1 got=%h exp=%h", v, 32'h0); end
      debug_step = 1'b1;
      step_n(3);
      rd_dbg(7'h20, v); total++; if (v !== 32'h4) begin bad++; $display("FAIL step_one_pc got=%h exp=%h", v, 32'h4); end
      rd_dbg(7'h01, v); total++; if (v !== 32'h1) begin bad++; $display("FAIL step_one_x1 got=%h exp=%h", v, 32'h1); end
      debug_step = 1'b0;
      step_n(2);
      debug_step = 1'b1;
      step_n(1);
      rd_dbg(7'h20, v); total++; if (v !== 32'h8) begin bad++; $display("FAIL step_two_pc got=%h exp=%h", v, 32'h8); end
      debug_en = 1'b0;
      debug_step = 1'b0;
      step_n(3);
      rd_dbg(7'h20, v); total++; if (v !== 32'h14) begin bad++; $display("FAIL back_to_back_pc got=%h exp=%h", v, 32'h14); end
   endtask

   initial begin
      test_reset();
      test_memory();
      test_alu_jump();
      test_branch();
      test_csr();
      test_interrupt();
      test_step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
